// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter/sequencer with ROM write protection
// One access at a time: IDLE picks a winner, ACCESS drives memory, DONE reports.
module dmem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 64,
  parameter int ROM_DEPTH  = 256,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_ctrl_w,
  output logic              mem_ctrl_r,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W+1)'(ROM_DEPTH);

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                err_q, err_d;
  logic                last_q, last_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                rom_hit;
  logic [DATA_W-1:0]   cap;

  assign rom_hit = {1'b0, addr_q} < ROM_LIMIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    err_d       = err_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    cap         = '0;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    p0_done     = 1'b0;
    p1_done     = 1'b0;
    p0_err      = 1'b0;
    p1_err      = 1'b0;
    mem_address = '0;
    mem_w_data  = '0;
    mem_ctrl_w  = 1'b0;
    mem_ctrl_r  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          if (p0_req && p1_req) begin
            win_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end else begin
            win_d = p1_req;
          end
          we_d    = win_d ? p1_we    : p0_we;
          addr_d  = win_d ? p1_addr  : p0_addr;
          wdata_d = win_d ? p1_wdata : p0_wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        p0_gnt      = ~win_q;
        p1_gnt      = win_q;
        mem_address = addr_q;
        mem_ctrl_r  = ~we_q;
        mem_ctrl_w  = we_q && !rom_hit;
        mem_w_data  = (we_q && !rom_hit) ? wdata_q : '0;
        cap         = we_q ? '0 : mem_r_data;
        if (win_q) rdata1_d = cap;
        else       rdata0_d = cap;
        err_d   = we_q && rom_hit;
        last_d  = win_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Requests are deliberately ignored here; a held req is picked up in IDLE.
        p0_done = ~win_q;
        p1_done = win_q;
        p0_err  = ~win_q && err_q;
        p1_err  = win_q && err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign p0_rdata     = rdata0_q;
  assign p1_rdata     = rdata1_q;
  assign busy         = (state_q == S_ACCESS) || (state_q == S_DONE);
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
// DUT a is round-robin with a ROM/RAM model; DUT b is fixed-priority, read-only.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_p0_req, a_p0_we, a_p0_gnt, a_p0_done, a_p0_err;
  logic [8:0]  a_p0_addr;
  logic [63:0] a_p0_wdata, a_p0_rdata;
  logic        a_p1_req, a_p1_we, a_p1_gnt, a_p1_done, a_p1_err;
  logic [8:0]  a_p1_addr;
  logic [63:0] a_p1_wdata, a_p1_rdata;
  logic [8:0]  a_mem_address;
  logic [63:0] a_mem_w_data, a_mem_r_data;
  logic        a_mem_ctrl_w, a_mem_ctrl_r, a_busy;
  logic [15:0] a_conflict_cnt;

  logic        b_p0_req, b_p0_gnt, b_p0_done, b_p0_err;
  logic [63:0] b_p0_rdata;
  logic        b_p1_req, b_p1_gnt, b_p1_done, b_p1_err;
  logic [63:0] b_p1_rdata;
  logic [8:0]  b_mem_address;
  logic [63:0] b_mem_w_data, b_mem_r_data;
  logic        b_mem_ctrl_w, b_mem_ctrl_r, b_busy;
  logic [15:0] b_conflict_cnt;

  logic [63:0] ram [0:511];

  function automatic logic [63:0] rom_word(input logic [8:0] a);
    return (a == 9'h005) ? 64'h1122334455667788 : {48'hC0DE_0000_0000, 7'd0, a};
  endfunction

  assign a_mem_r_data = (a_mem_address[8] == 1'b0) ? rom_word(a_mem_address) : ram[a_mem_address];
  assign b_mem_r_data = (b_mem_address[8] == 1'b0) ? rom_word(b_mem_address) : ram[b_mem_address];

  always @(posedge clk) if (a_mem_ctrl_w) ram[a_mem_address] <= a_mem_w_data;

  dmem_arbiter #(.ADDR_W(9), .DATA_W(64), .ROM_DEPTH(256), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .rst(rst),
    .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_gnt(a_p0_gnt), .p0_done(a_p0_done), .p0_rdata(a_p0_rdata), .p0_err(a_p0_err),
    .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_gnt(a_p1_gnt), .p1_done(a_p1_done), .p1_rdata(a_p1_rdata), .p1_err(a_p1_err),
    .mem_address(a_mem_address), .mem_w_data(a_mem_w_data), .mem_ctrl_w(a_mem_ctrl_w),
    .mem_ctrl_r(a_mem_ctrl_r), .mem_r_data(a_mem_r_data), .busy(a_busy),
    .conflict_cnt(a_conflict_cnt)
  );

  dmem_arbiter #(.ADDR_W(9), .DATA_W(64), .ROM_DEPTH(256), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_we(1'b0), .p0_addr(9'h005), .p0_wdata(64'd0),
    .p0_gnt(b_p0_gnt), .p0_done(b_p0_done), .p0_rdata(b_p0_rdata), .p0_err(b_p0_err),
    .p1_req(b_p1_req), .p1_we(1'b0), .p1_addr(9'h020), .p1_wdata(64'd0),
    .p1_gnt(b_p1_gnt), .p1_done(b_p1_done), .p1_rdata(b_p1_rdata), .p1_err(b_p1_err),
    .mem_address(b_mem_address), .mem_w_data(b_mem_w_data), .mem_ctrl_w(b_mem_ctrl_w),
    .mem_ctrl_r(b_mem_ctrl_r), .mem_r_data(b_mem_r_data), .busy(b_busy),
    .conflict_cnt(b_conflict_cnt)
  );

  // One access on dut_a, starting at the current negedge with the DUT in IDLE.
  task automatic run_a(input bit port, input bit we, input logic [8:0] addr, input logic [63:0] wd,
                       output int gnt_at, output int done_at, output int nw, output int nr,
                       output logic [8:0] gaddr, output logic [63:0] rd, output logic er);
    gnt_at = -1; done_at = -1; nw = 0; nr = 0; gaddr = '0; rd = '0; er = 1'b0;
    if (port) begin
      a_p1_req = 1'b1; a_p1_we = we; a_p1_addr = addr; a_p1_wdata = wd;
    end else begin
      a_p0_req = 1'b1; a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wd;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (a_mem_ctrl_w) nw++;
      if (a_mem_ctrl_r) nr++;
      if ((port ? a_p1_gnt : a_p0_gnt) && gnt_at < 0) begin
        gnt_at = k; gaddr = a_mem_address; a_p0_req = 1'b0; a_p1_req = 1'b0;
      end
      if (port ? a_p1_done : a_p0_done) begin
        done_at = k; rd = port ? a_p1_rdata : a_p0_rdata; er = port ? a_p1_err : a_p0_err;
        break;
      end
    end
    a_p0_req = 1'b0; a_p1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({a_p0_gnt, a_p1_gnt, a_p0_done, a_p1_done, a_p0_err, a_p1_err, a_busy} !== 7'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {a_p0_gnt, a_p1_gnt, a_p0_done, a_p1_done, a_p0_err, a_p1_err, a_busy}); end
    checks++; if ({a_mem_ctrl_w, a_mem_ctrl_r, a_mem_address, a_mem_w_data} !== 75'd0) begin
      errors++; $display("FAIL reset_mem: got ctrl_w=%b ctrl_r=%b addr=%h wdata=%h want 0", a_mem_ctrl_w, a_mem_ctrl_r, a_mem_address, a_mem_w_data); end
    checks++; if ({a_p0_rdata, a_p1_rdata, a_conflict_cnt} !== 144'd0) begin
      errors++; $display("FAIL reset_data: got rd0=%h rd1=%h cnt=%0d want 0", a_p0_rdata, a_p1_rdata, a_conflict_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_rom_read;
    int g, d, nw, nr; logic [8:0] ga; logic [63:0] rd; logic er;
    run_a(1'b0, 1'b0, 9'h005, 64'd0, g, d, nw, nr, ga, rd, er);
    checks++; if (g !== 1 || d !== 2) begin errors++; $display("FAIL read_timing: got gnt=%0d done=%0d want 1 2", g, d); end
    checks++; if (nr !== 1 || nw !== 0) begin errors++; $display("FAIL read_ctrl: got r=%0d w=%0d want 1 0", nr, nw); end
    checks++; if (ga !== 9'h005) begin errors++; $display("FAIL read_addr: got %h want 005", ga); end
    checks++; if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
      errors++; $display("FAIL read_data: got %h err=%b want 1122334455667788 0", rd, er); end
    checks++; if (a_p0_rdata !== 64'h1122334455667788 || a_busy !== 1'b0) begin
      errors++; $display("FAIL read_hold: got %h busy=%b want held data, busy 0", a_p0_rdata, a_busy); end
  endtask

  task automatic test_ram_write_read;
    int g, d, nw, nr; logic [8:0] ga; logic [63:0] rd; logic er;
    run_a(1'b1, 1'b1, 9'h1F0, 64'hDEAD, g, d, nw, nr, ga, rd, er);
    checks++; if (nw !== 1 || nr !== 0 || er !== 1'b0 || d !== 2) begin
      errors++; $display("FAIL ram_write: got w=%0d r=%0d err=%b done=%0d want 1 0 0 2", nw, nr, er, d); end
    checks++; if (ram[9'h1F0] !== 64'hDEAD) begin errors++; $display("FAIL ram_cell: got %h want dead", ram[9'h1F0]); end
    run_a(1'b1, 1'b0, 9'h1F0, 64'd0, g, d, nw, nr, ga, rd, er);
    checks++; if (rd !== 64'hDEAD || nr !== 1 || g !== 1) begin
      errors++; $display("FAIL ram_read: got %h r=%0d gnt=%0d want dead 1 1", rd, nr, g); end
  endtask

  task automatic test_rom_write;
    int g, d, nw, nr; logic [8:0] ga; logic [63:0] rd; logic er;
    run_a(1'b0, 1'b1, 9'h010, 64'hBAD, g, d, nw, nr, ga, rd, er);
    checks++; if (nw !== 0 || nr !== 0) begin errors++; $display("FAIL rom_write_ctrl: got w=%0d r=%0d want 0 0", nw, nr); end
    checks++; if (er !== 1'b1 || d !== 2 || rd !== 64'd0) begin
      errors++; $display("FAIL rom_write_err: got err=%b done=%0d rd=%h want 1 2 0", er, d, rd); end
    checks++; if (a_p0_err !== 1'b0) begin errors++; $display("FAIL rom_err_clear: got %b want 0", a_p0_err); end
    run_a(1'b0, 1'b0, 9'h010, 64'd0, g, d, nw, nr, ga, rd, er);
    checks++; if (rd !== 64'hC0DE000000000010 || er !== 1'b0) begin
      errors++; $display("FAIL rom_unchanged: got %h err=%b want c0de000000000010 0", rd, er); end
  endtask

  task automatic test_arbitration;
    int ga [4]; int gb [5]; int na, nb; bit both;
    na = 0; nb = 0; both = 1'b0;
    rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0;
    a_p0_req = 1'b1; a_p0_we = 1'b0; a_p0_addr = 9'h005;
    a_p1_req = 1'b1; a_p1_we = 1'b0; a_p1_addr = 9'h1F0;
    b_p0_req = 1'b1; b_p1_req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (a_p0_gnt && a_p1_gnt) both = 1'b1;
      if (a_p0_gnt) begin if (na < 4) ga[na] = 0; na++; end
      if (a_p1_gnt) begin if (na < 4) ga[na] = 1; na++; end
      if (b_p0_gnt) begin if (nb < 5) gb[nb] = 0; nb++; end
      if (b_p1_gnt) begin if (nb < 5) gb[nb] = 1; nb++; end
      if (k == 10) begin a_p0_req = 1'b0; a_p1_req = 1'b0; b_p0_req = 1'b0; end
      if (k == 13) b_p1_req = 1'b0;
    end
    checks++; if (na !== 4 || both) begin errors++; $display("FAIL rr_count: got %0d both=%b want 4 0", na, both); end
    checks++; if (na == 4 && (ga[0] !== 0 || ga[1] !== 1 || ga[2] !== 0 || ga[3] !== 1)) begin
      errors++; $display("FAIL rr_order: got %0d%0d%0d%0d want 0101", ga[0], ga[1], ga[2], ga[3]); end
    checks++; if (a_conflict_cnt !== 16'd4) begin errors++; $display("FAIL rr_conflicts: got %0d want 4", a_conflict_cnt); end
    checks++; if (nb !== 5) begin errors++; $display("FAIL fixed_count: got %0d want 5", nb); end
    checks++; if (nb == 5 && (gb[0] !== 0 || gb[1] !== 0 || gb[2] !== 0 || gb[3] !== 0 || gb[4] !== 1)) begin
      errors++; $display("FAIL fixed_order: got %0d%0d%0d%0d%0d want 00001", gb[0], gb[1], gb[2], gb[3], gb[4]); end
    checks++; if (b_conflict_cnt !== 16'd4) begin errors++; $display("FAIL fixed_conflicts: got %0d want 4", b_conflict_cnt); end
    checks++; if (b_p1_rdata !== 64'hC0DE000000000020 || b_busy !== 1'b0) begin
      errors++; $display("FAIL fixed_p1_data: got %h busy=%b want c0de000000000020 0", b_p1_rdata, b_busy); end
  endtask

  task automatic test_reset_mid_access;
    int g, d, nw, nr; logic [8:0] ga; logic [63:0] rd, old; logic er; bit seen;
    old = ram[9'h180]; seen = 1'b0;
    a_p0_req = 1'b1; a_p0_we = 1'b1; a_p0_addr = 9'h180; a_p0_wdata = 64'h1234;
    @(negedge clk);
    checks++; if (a_mem_ctrl_w !== 1'b1 || a_p0_gnt !== 1'b1) begin
      errors++; $display("FAIL abort_access: got ctrl_w=%b gnt=%b want 1 1", a_mem_ctrl_w, a_p0_gnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_mem_ctrl_w, a_mem_ctrl_r, a_p0_gnt, a_busy, a_mem_address} !== 13'd0) begin
      errors++; $display("FAIL abort_async: got ctrl_w=%b ctrl_r=%b gnt=%b busy=%b addr=%h want 0", a_mem_ctrl_w, a_mem_ctrl_r, a_p0_gnt, a_busy, a_mem_address); end
    checks++; if (a_p0_rdata !== 64'd0 || a_conflict_cnt !== 16'd0) begin
      errors++; $display("FAIL abort_regs: got rd=%h cnt=%0d want 0 0", a_p0_rdata, a_conflict_cnt); end
    a_p0_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) begin @(negedge clk); if (a_p0_done || a_p1_done) seen = 1'b1; end
    checks++; if (seen || ram[9'h180] !== old) begin
      errors++; $display("FAIL abort_effect: got done=%b ram=%h want 0 %h", seen, ram[9'h180], old); end
    run_a(1'b1, 1'b0, 9'h005, 64'd0, g, d, nw, nr, ga, rd, er);
    checks++; if (g !== 1 || d !== 2 || rd !== 64'h1122334455667788) begin
      errors++; $display("FAIL abort_recover: got gnt=%0d done=%0d rd=%h want 1 2 1122334455667788", g, d, rd); end
  endtask

  initial begin
    a_p0_req = 1'b0; a_p0_we = 1'b0; a_p0_addr = '0; a_p0_wdata = '0;
    a_p1_req = 1'b0; a_p1_we = 1'b0; a_p1_addr = '0; a_p1_wdata = '0;
    b_p0_req = 1'b0; b_p1_req = 1'b0;
    test_reset;
    test_rom_read;
    test_ram_write_read;
    test_rom_write;
    test_arbitration;
    test_reset_mid_access;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
